cs_bus_sequencer: RTL and testbench
===================================

Name: cs_bus_sequencer

Overview:
Synchronous bus-cycle controller for the four-chip peripheral space behind the active-low chip-select decode. It accepts a single-master request, decodes the top 3 address bits to one of CS1..CS4, and sequences setup, access (per-chip wait states) and hold phases with active-low strobes. It returns a done/err pulse and captured read data. It sits between the CPU-side bus interface and the external chip pins.

Parameters:
ADDR_W, 16, request address width; bits [ADDR_W-1:ADDR_W-3] are the chip-select field
DATA_W, 8, data bus width
SETUP_CYC, 1, cycles CS is low before the strobe (1..15)
HOLD_CYC, 1, cycles CS stays low after the strobe (0..15)
WAIT1, 0, extra access cycles for CS1 (0..15); WAIT2, WAIT3 and WAIT4 are the same for CS2..CS4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  access request, level; sampled only in IDLE
wr  in  1  1 = write, 0 = read; captured with req
addr  in  ADDR_W  access address; captured with req
wdata  in  DATA_W  write data; captured with req
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done for an unmapped address
rdata  out  DATA_W  read data, valid from the done cycle and held until the next read completes
cs_n  out  4  active-low chip selects; bit0 = CS1 … bit3 = CS4
oe_n  out  1  active-low output enable (read strobe)
we_n  out  1  active-low write enable
mem_addr  out  ADDR_W-3  registered low address bits to the chips
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  chip read data

Behaviour:
- Reset (async, rst_n low): state IDLE; cs_n=4'b1111; oe_n=1; we_n=1; busy=0; done=0; err=0; rdata=0; mem_addr=0; mem_wdata=0. Reset mid-cycle releases all strobes immediately, and the transfer is lost.
- Chip map on field addr[ADDR_W-1:ADDR_W-3]: 3'b100 maps to CS1, 101 to CS2, 010 to CS3, 011 to CS4. Codes 000, 001, 110 and 111 are unmapped.
- All outputs are registered. At most one cs_n bit is low at any time, and cs_n is 4'b1111 in IDLE and ERR.
- FSM states: IDLE, SETUP, ACCESS, HOLD, ERR.
- IDLE: if req=1, capture wr, addr and wdata.
  - Mapped address: go to SETUP and load the counter with SETUP_CYC-1.
  - Unmapped address: go to ERR.
  - req is ignored in every state except IDLE.
- SETUP: selected cs_n low; oe_n and we_n high. When the counter reaches 0, go to ACCESS and load the counter with WAITn (per selected chip).
- ACCESS: cs_n low; we_n=0 if wr, else oe_n=0. Length is WAITn+1 cycles.
  - On the last ACCESS cycle of a read, capture mem_rdata into rdata.
  - Next state is HOLD if HOLD_CYC>0, else IDLE.
- HOLD: strobes high, cs_n still low, for HOLD_CYC cycles, then IDLE.
- Completion: done=1 (and busy=0) in the first IDLE cycle after a transfer. A req present in that same cycle is accepted, so there is at least one cs_n-high cycle between back-to-back accesses.
- ERR: one cycle with no strobes. Next cycle is IDLE with done=1 and err=1. rdata is unchanged.
- Latency from the req-sampled cycle to done is 1 + SETUP_CYC + (WAITn+1) + HOLD_CYC cycles. With defaults and WAITn=0 this is 4.
- The counter is 4 bits wide. Parameter ranges are checked at elaboration; out-of-range values are a fatal error.
- Request fields (wr, addr, wdata) may change while busy without effect.

Decomposition:
- Shared package/include holds:
  - chip codes CHIP1=3'b100, CHIP2=3'b101, CHIP3=3'b010, CHIP4=3'b011
  - FSM state encodings
  - the cs_n idle constant 4'b1111
- One sub-module, cs_addr_decode (combinational): 3-bit field in; one-hot active-low cs vector, valid flag and 2-bit chip index out. The chip index selects WAITn.

Test Plan:
1. Reset release, then idle for 5 cycles -> cs_n=1111, oe_n=we_n=1, busy=done=err=0 throughout.
2. Read addr=16'h8012 (CS1), WAIT1=2, defaults otherwise, mem_rdata=8'hA5 -> cs_n=1110 for 5 cycles, oe_n low for 3; done at cycle 6 after req; rdata=A5; mem_addr=13'h0012.
3. Write addr=16'h6004 (CS4), wdata=8'h3C, WAIT4=0 -> cs_n=0111 for 3 cycles, we_n low for 1; mem_wdata=3C; done 4 cycles after req; oe_n stays high.
4. Read at addr=16'hE000 (unmapped) -> no cs_n/oe_n/we_n activity; done=err=1 exactly one cycle, 2 cycles after req; rdata unchanged.
5. req held high across two CS2/CS3 accesses -> second accepted in the done cycle; exactly one cs_n=1111 cycle between them; cs_n never has two bits low.
6. rst_n pulsed low mid-ACCESS of a write -> cs_n=1111 and we_n=1 asynchronously; no done; the next req completes normally.

Source files
------------

// File: rtl/cs_bus_sequencer_pkg.sv
// Shared constants for the chip-select bus sequencer: chip codes, FSM states, idle select value.
package cs_bus_sequencer_pkg;

  localparam logic [2:0] CHIP1 = 3'b100;
  localparam logic [2:0] CHIP2 = 3'b101;
  localparam logic [2:0] CHIP3 = 3'b010;
  localparam logic [2:0] CHIP4 = 3'b011;

  localparam logic [3:0] CsNIdle = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StErr
  } state_e;

endpackage

// File: rtl/cs_bus_sequencer_if.sv
// CPU-side request/completion bundle of the chip-select bus sequencer.
interface cs_bus_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, wdata, input busy, done, err, rdata);
  modport slave  (input req, wr, addr, wdata, output busy, done, err, rdata);
endinterface

// File: rtl/cs_bus_sequencer_addr_decode.sv
// Maps the 3-bit chip-select field to an active-low select, a valid flag and a chip index.
module cs_addr_decode
  import cs_bus_sequencer_pkg::*;
(
  input  logic [2:0] field_i,
  output logic [3:0] cs_n_o,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  always_comb begin
    cs_n_o  = CsNIdle;
    valid_o = 1'b0;
    idx_o   = 2'd0;
    case (field_i)
      CHIP1:   begin cs_n_o = 4'b1110; valid_o = 1'b1; idx_o = 2'd0; end
      CHIP2:   begin cs_n_o = 4'b1101; valid_o = 1'b1; idx_o = 2'd1; end
      CHIP3:   begin cs_n_o = 4'b1011; valid_o = 1'b1; idx_o = 2'd2; end
      CHIP4:   begin cs_n_o = 4'b0111; valid_o = 1'b1; idx_o = 2'd3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cs_bus_sequencer.sv
// Bus-cycle controller: decodes a request to CS1..CS4 and sequences setup, access and hold
// phases with registered active-low strobes.
module cs_bus_sequencer
  import cs_bus_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned WAIT1     = 0,
  parameter int unsigned WAIT2     = 0,
  parameter int unsigned WAIT3     = 0,
  parameter int unsigned WAIT4     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cs_bus_sequencer_if.slave       bus,
  output logic [3:0]              cs_n_o,
  output logic                    oe_n_o,
  output logic                    we_n_o,
  output logic [ADDR_W-4:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic [DATA_W-1:0]       mem_rdata_i
);

  if (ADDR_W < 4 || SETUP_CYC < 1 || SETUP_CYC > 15 || HOLD_CYC > 15 ||
      WAIT1 > 15 || WAIT2 > 15 || WAIT3 > 15 || WAIT4 > 15) begin : gen_param_check
    $fatal(1, "cs_bus_sequencer: parameter out of range");
  end

  localparam logic [3:0] SetupLoad = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HoldLoad  = 4'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          chip_q, chip_d;
  logic                wr_q, wr_d;
  logic [3:0]          cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-4:0]   mem_addr_q, mem_addr_d;

  logic [3:0] dec_cs_n;
  logic       dec_valid;
  logic [1:0] dec_idx;
  logic [3:0] wait_sel;

  cs_addr_decode u_decode (
    .field_i (bus.addr[ADDR_W-1 -: 3]),
    .cs_n_o  (dec_cs_n),
    .valid_o (dec_valid),
    .idx_o   (dec_idx)
  );

  always_comb begin
    case (chip_q)
      2'd0:    wait_sel = 4'(WAIT1);
      2'd1:    wait_sel = 4'(WAIT2);
      2'd2:    wait_sel = 4'(WAIT3);
      default: wait_sel = 4'(WAIT4);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chip_d      = chip_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          wr_d        = bus.wr;
          mem_addr_d  = bus.addr[ADDR_W-4:0];
          mem_wdata_d = bus.wdata;
          chip_d      = dec_idx;
          if (dec_valid) begin
            state_d = StSetup;
            cnt_d   = SetupLoad;
          end else begin
            state_d = StErr;
          end
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
          cnt_d   = wait_sel;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = mem_rdata_i;
          if (HOLD_CYC > 0) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    cs_n_d = CsNIdle;
    if (state_d inside {StSetup, StAccess, StHold}) begin
      cs_n_d = (state_q == StIdle) ? dec_cs_n : cs_n_q;
    end
    oe_n_d = !((state_d == StAccess) && !wr_d);
    we_n_d = !((state_d == StAccess) && wr_d);
    busy_d = (state_d != StIdle);
    done_d = (state_q != StIdle) && (state_d == StIdle);
    err_d  = (state_q == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      chip_q      <= 2'd0;
      wr_q        <= 1'b0;
      cs_n_q      <= CsNIdle;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chip_q      <= chip_d;
      wr_q        <= wr_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign cs_n_o      = cs_n_q;
  assign oe_n_o      = oe_n_q;
  assign we_n_o      = we_n_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cs_bus_sequencer.sv
// Directed plus randomized bench for cs_bus_sequencer against a transaction-level timing model.
module tb_cs_bus_sequencer;

  localparam int SETUP = 1;
  localparam int HOLD  = 1;
  localparam int W1 = 2, W2 = 1, W3 = 3, W4 = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cs_n;
  logic        oe_n, we_n;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;
  logic [7:0] rdata_exp = 8'h00;
  int wait_tbl [4] = '{W1, W2, W3, W4};

  cs_bus_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus_if ();

  cs_bus_sequencer #(
    .ADDR_W(16), .DATA_W(8), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD),
    .WAIT1(W1), .WAIT2(W2), .WAIT3(W3), .WAIT4(W4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .cs_n_o      (cs_n),
    .oe_n_o      (oe_n),
    .we_n_o      (we_n),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total += 1;
    assert (obs === exp) passed += 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Chip map from the address field; -1 means unmapped.
  function automatic int chip_of(input logic [2:0] f);
    case (f)
      3'b100:  return 0;
      3'b101:  return 1;
      3'b010:  return 2;
      3'b011:  return 3;
      default: return -1;
    endcase
  endfunction

  // One request issued from IDLE; compares the whole transfer against the model.
  task automatic do_xfer(input logic w, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input string tag);
    int ch, lat_exp, lat, cs_cnt, cs_bad, oe_cnt, we_cnt, busy_bad, multi;
    logic err_seen;
    logic [3:0] cs_exp;
    ch = chip_of(a[15:13]);
    lat_exp = (ch < 0) ? 2 : 1 + SETUP + wait_tbl[ch] + 1 + HOLD;
    cs_exp  = (ch < 0) ? 4'hF : ~(4'b0001 << ch);
    lat = 0; cs_cnt = 0; cs_bad = 0; oe_cnt = 0; we_cnt = 0; busy_bad = 0; multi = 0;
    err_seen = 1'b0;
    mem_rdata     = rd;
    bus_if.req    = 1'b1;
    bus_if.wr     = w;
    bus_if.addr   = a;
    bus_if.wdata  = wd;
    @(posedge clk);
    for (int k = 1; k <= 64 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_if.req   = 1'b0;
        bus_if.wr    = ~w;
        bus_if.addr  = 16'($urandom);
        bus_if.wdata = 8'($urandom);
      end
      if (cs_n != 4'hF) begin
        cs_cnt++;
        if (cs_n != cs_exp) cs_bad++;
      end
      if ($countones(~cs_n) > 1) multi++;
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (bus_if.done) begin
        lat = k;
        err_seen = bus_if.err;
        if (bus_if.busy) busy_bad++;
      end else if (!bus_if.busy) begin
        busy_bad++;
      end
    end
    if (ch >= 0 && !w) rdata_exp = rd;
    check({tag, "/latency"}, 32'(lat), 32'(lat_exp));
    check({tag, "/cs_cycles"}, 32'(cs_cnt), (ch < 0) ? 32'd0 : 32'(SETUP + wait_tbl[ch] + 1 + HOLD));
    check({tag, "/cs_wrong_chip"}, 32'(cs_bad), 32'd0);
    check({tag, "/cs_multi_low"}, 32'(multi), 32'd0);
    check({tag, "/oe_cycles"}, 32'(oe_cnt), (ch >= 0 && !w) ? 32'(wait_tbl[ch] + 1) : 32'd0);
    check({tag, "/we_cycles"}, 32'(we_cnt), (ch >= 0 && w) ? 32'(wait_tbl[ch] + 1) : 32'd0);
    check({tag, "/busy"}, 32'(busy_bad), 32'd0);
    check({tag, "/err"}, 32'(err_seen), (ch < 0) ? 32'd1 : 32'd0);
    check({tag, "/rdata"}, 32'(bus_if.rdata), 32'(rdata_exp));
    if (ch >= 0) check({tag, "/mem_addr"}, 32'(mem_addr), 32'(a[12:0]));
    if (ch >= 0 && w) check({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(wd));
    @(negedge clk);
    check({tag, "/done_pulse"}, {29'd0, bus_if.done, bus_if.err, bus_if.busy}, 32'd0);
    check({tag, "/cs_idle_after"}, 32'(cs_n), 32'hF);
  endtask

  initial begin
    int bad, n_idle, d1, d2, dones;
    logic [3:0] cs_at [0:15];
    logic [2:0] f;

    rst_n = 1'b1;
    bus_if.req = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    mem_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset/outputs", {22'd0, cs_n, oe_n, we_n, bus_if.busy, bus_if.done, bus_if.err,
                            1'b0}, {22'd0, 4'hF, 1'b1, 1'b1, 4'b0000});
    check("reset/rdata", 32'(bus_if.rdata), 32'd0);
    check("reset/mem", {11'd0, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset release
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (cs_n != 4'hF || !oe_n || !we_n || bus_if.busy || bus_if.done || bus_if.err) bad++;
    end
    check("idle/quiet", 32'(bad), 32'd0);

    // 2..4: directed transfers
    do_xfer(1'b0, 16'h8012, 8'h00, 8'hA5, "read_cs1");
    do_xfer(1'b1, 16'h6004, 8'h3C, 8'h5A, "write_cs4");
    do_xfer(1'b0, 16'hE000, 8'h00, 8'h77, "unmapped");

    // 5: req held across CS2 then CS3; second accepted in first done cycle
    d1 = 0; d2 = 0; bad = 0; n_idle = 0;
    mem_rdata = 8'hC3;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 16'hA002;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus_if.addr = 16'h4010;
      if (k == 6) bus_if.req = 1'b0;
      cs_at[k] = cs_n;
      if ($countones(~cs_n) > 1) bad++;
      if (bus_if.done && d1 == 0) d1 = k;
      else if (bus_if.done && d2 == 0) d2 = k;
      if (k < 12 && cs_n == 4'hF) n_idle++;
    end
    rdata_exp = 8'hC3;
    check("b2b/first_done", 32'(d1), 32'(1 + SETUP + W2 + 1 + HOLD));
    check("b2b/second_done", 32'(d2), 32'(1 + SETUP + W2 + 1 + HOLD + 1 + SETUP + W3 + 1 + HOLD));
    check("b2b/gap_cycles", 32'(n_idle), 32'd1);
    check("b2b/multi_low", 32'(bad), 32'd0);
    check("b2b/cs2", 32'(cs_at[4]), 32'hD);
    check("b2b/cs3", 32'(cs_at[6]), 32'hB);
    check("b2b/rdata", 32'(bus_if.rdata), 32'(rdata_exp));

    // 6: reset in the middle of a CS1 write access
    bus_if.req = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 16'h8100; bus_if.wdata = 8'h99;
    @(posedge clk);
    @(negedge clk); bus_if.req = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_mid/we_active", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid/strobes", {27'd0, cs_n, we_n}, {27'd0, 4'hF, 1'b1});
    check("rst_mid/status", {29'd0, bus_if.busy, bus_if.done, bus_if.err}, 32'd0);
    rdata_exp = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done || cs_n != 4'hF) dones++;
    end
    check("rst_mid/no_done", 32'(dones), 32'd0);
    do_xfer(1'b1, 16'h8055, 8'h42, 8'h00, "after_rst");

    // Randomized transfers over all eight field codes
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      do_xfer(1'($urandom_range(0, 1)), {f, 13'($urandom)}, 8'($urandom), 8'($urandom), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
